// File: rtl/mips_core_pkg.sv
// Branch predictor shared types: 2-bit direction counter, table entry and counter next-state.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_counter_t;

    // Tag is kept at full address width; the unused upper bits are always written as zero.
    typedef struct packed {
        logic                   valid;
        logic [`ADDR_WIDTH-1:0] tag;
        logic [`ADDR_WIDTH-1:0] target;
        bp_counter_t            counter;
    } bp_entry_t;

    function automatic bp_counter_t bp_counter_next(input bp_counter_t cur, input logic taken);
        bp_counter_t nxt;
        nxt = cur;
        case (cur)
            STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
            default:   nxt = WEAK_NT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_prediction_ifc.sv
// Prediction bundle returned to fetch for the current PC.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface branch_prediction_ifc;
    logic                   is_branch;
    logic                   prediction;
    logic [`ADDR_WIDTH-1:0] target;

    modport in  (input is_branch, prediction, target);
    modport out (output is_branch, prediction, target);
endinterface

// File: rtl/pc_ifc.sv
// Fetch PC bundle.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface pc_ifc;
    logic [`ADDR_WIDTH-1:0] pc;

    modport in  (input pc);
    modport out (output pc);
endinterface

// File: rtl/bp_sat_counter.sv
// 2-bit saturating direction counter update.

module bp_sat_counter
    import mips_core_pkg::*;
(
    input  bp_counter_t i_counter,
    input  logic        i_taken,
    output bp_counter_t o_counter
);

    assign o_counter = bp_counter_next(i_counter, i_taken);

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; combinational lookup, clocked update.
// Optional statistics outputs are enabled by defining BRANCH_PREDICTOR_STATS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_predictor
    import mips_core_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    pc_ifc.in                      i_pc_current,
    branch_prediction_ifc.out      o_prediction,
    input  logic                   i_update_valid,
    input  logic [`ADDR_WIDTH-1:0] i_update_pc,
    input  logic                   i_update_is_branch,
    input  logic                   i_update_taken,
    input  logic [`ADDR_WIDTH-1:0] i_update_target,
`ifdef BRANCH_PREDICTOR_STATS_EN
    output logic [31:0]            o_branch_count,
    output logic [31:0]            o_mispredict_count,
`endif
    input  logic                   i_update_mispredict
);

    localparam int unsigned DEPTH = 1 << INDEX_BITS;

    bp_entry_t entries_q [DEPTH];

    // Lookup path
    logic [INDEX_BITS-1:0]  lk_idx;
    logic [`ADDR_WIDTH-1:0] lk_tag;
    bp_entry_t              lk_entry;
    logic                   lk_hit;

    assign lk_idx   = i_pc_current.pc[INDEX_BITS+1:2];
    assign lk_tag   = i_pc_current.pc >> (INDEX_BITS + 2);
    assign lk_entry = entries_q[lk_idx];
    assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);

    always_comb begin
        o_prediction.is_branch  = 1'b0;
        o_prediction.prediction = 1'b0;
        o_prediction.target     = '0;
        if (!rst && lk_hit) begin
            o_prediction.is_branch  = 1'b1;
            o_prediction.prediction = lk_entry.counter[1];
            o_prediction.target     = lk_entry.target;
        end
    end

    // Update path
    logic [INDEX_BITS-1:0]  upd_idx;
    logic [`ADDR_WIDTH-1:0] upd_tag;
    bp_entry_t              upd_entry;
    logic                   upd_hit;
    bp_counter_t            upd_counter_next;
    bp_entry_t              new_entry;
    logic                   upd_write;

    assign upd_idx   = i_update_pc[INDEX_BITS+1:2];
    assign upd_tag   = i_update_pc >> (INDEX_BITS + 2);
    assign upd_entry = entries_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    bp_sat_counter u_sat_counter (
        .i_counter (upd_entry.counter),
        .i_taken   (i_update_taken),
        .o_counter (upd_counter_next)
    );

    always_comb begin
        upd_write = 1'b0;
        new_entry = upd_entry;
        if (i_update_valid) begin
            if (i_update_is_branch) begin
                upd_write = 1'b1;
                if (upd_hit) begin
                    new_entry.counter = upd_counter_next;
                    if (i_update_taken) begin
                        new_entry.target = i_update_target;
                    end
                end else begin
                    // Allocation replaces whatever aliased into this slot.
                    new_entry.valid   = 1'b1;
                    new_entry.tag     = upd_tag;
                    new_entry.target  = i_update_target;
                    new_entry.counter = i_update_taken ? WEAK_T : WEAK_NT;
                end
            end else if (upd_hit) begin
                upd_write       = 1'b1;
                new_entry.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, counter: WEAK_NT};
            end
        end else if (upd_write) begin
            entries_q[upd_idx] <= new_entry;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;
    logic        count_branch;

    assign count_branch = i_update_valid && i_update_is_branch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (count_branch) begin
            if (branch_cnt_q != 32'hFFFF_FFFF) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (i_update_mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign o_branch_count     = branch_cnt_q;
    assign o_mispredict_count = mispredict_cnt_q;
`else
    logic unused_mispredict;
    assign unused_mispredict = i_update_mispredict;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios, then random traffic vs a table model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_predictor;

    localparam int IB    = 6;
    localparam int DEPTH = 1 << IB;

    logic        clk;
    logic        rst;
    logic        u_valid;
    logic [31:0] u_pc;
    logic        u_branch;
    logic        u_taken;
    logic [31:0] u_target;
    logic        u_mis;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
`endif

    pc_ifc                pc_if ();
    branch_prediction_ifc pred_if ();

    branch_predictor #(.INDEX_BITS(IB)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_pc_current        (pc_if),
        .o_prediction        (pred_if),
        .i_update_valid      (u_valid),
        .i_update_pc         (u_pc),
        .i_update_is_branch  (u_branch),
        .i_update_taken      (u_taken),
        .i_update_target     (u_target),
`ifdef BRANCH_PREDICTOR_STATS_EN
        .o_branch_count      (branch_count),
        .o_mispredict_count  (mispredict_count),
`endif
        .i_update_mispredict (u_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: one slot per index, direction strength as a plain integer 0..3.
    bit          m_valid [DEPTH];
    logic [31:0] m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];
    longint      m_bc;
    longint      m_mc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (IB + 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic model_update();
        int  i;
        bit  hit;
        i   = idx_of(u_pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(u_pc));
        if (u_valid) begin
            if (u_branch) begin
                if (hit) begin
                    if (u_taken) begin
                        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = u_target;
                    end else begin
                        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    end
                end else begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = tag_of(u_pc);
                    m_tgt[i]   = u_target;
                    m_ctr[i]   = u_taken ? 2 : 1;
                end
                if (m_bc < 64'hFFFF_FFFF) m_bc++;
                if (u_mis && m_mc < 64'hFFFF_FFFF) m_mc++;
            end else if (hit) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic check_model(input string name);
        logic [31:0] pc;
        int          i;
        bit          hit;
        pc  = pc_if.pc;
        i   = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        check({name, ".is_branch"}, 32'(pred_if.is_branch), 32'(hit));
        check({name, ".prediction"}, 32'(pred_if.prediction), 32'(hit && m_ctr[i] >= 2));
        check({name, ".target"}, pred_if.target, hit ? m_tgt[i] : 32'h0);
`ifdef BRANCH_PREDICTOR_STATS_EN
        check({name, ".branch_count"}, branch_count, 32'(m_bc));
        check({name, ".mispredict_count"}, mispredict_count, 32'(m_mc));
`endif
    endtask

    task automatic check_const(input string name, input logic isb, input logic pred,
                               input logic [31:0] tgt);
        check({name, ".c_is_branch"}, 32'(pred_if.is_branch), 32'(isb));
        check({name, ".c_prediction"}, 32'(pred_if.prediction), 32'(pred));
        check({name, ".c_target"}, pred_if.target, tgt);
    endtask

    task automatic drive(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                         input logic ub, input logic ut, input logic [31:0] utgt,
                         input logic um);
        pc_if.pc = lpc;
        u_valid  = uv;
        u_pc     = upc;
        u_branch = ub;
        u_taken  = ut;
        u_target = utgt;
        u_mis    = um;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Lookup lpc while applying one update; checks pre-update contents.
    task automatic cycle(input string name, input logic [31:0] lpc, input logic [31:0] upc,
                         input logic ub, input logic ut, input logic [31:0] utgt);
        drive(lpc, 1'b1, upc, ub, ut, utgt, ut);
        #1;
        check_model(name);
        finish_cycle();
    endtask

    task automatic look(input string name, input logic [31:0] lpc, input logic isb,
                        input logic pred, input logic [31:0] tgt);
        drive(lpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        check_model(name);
        check_const(name, isb, pred, tgt);
        finish_cycle();
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] lpc;
        rst = 1'b0;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_const("in_reset", 1'b0, 1'b0, 32'h0);
        #10 rst = 1'b0;

        look("reset_miss", 32'h0000_0100, 1'b0, 1'b0, 32'h0);

        cycle("alloc_40", 32'h0000_0040, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0200);
        look("hit_40", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0200);

        cycle("nt1", 32'h0000_0040, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0bad);
        look("after_nt1", 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0200);
        cycle("nt2", 32'h0000_0040, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0bad);
        look("after_nt2", 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0200);
        cycle("nt3", 32'h0000_0040, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0bad);
        look("after_nt3", 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0200);
        // From STRONG_NT, one taken only reaches WEAK_NT.
        cycle("t_from_snt", 32'h0000_0040, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0200);
        look("after_t1", 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0200);
        cycle("t_to_wt", 32'h0000_0040, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0200);
        look("after_t2", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0200);

        cycle("alias_140", 32'h0000_0140, 32'h0000_0140, 1'b1, 1'b1, 32'h0000_0300);
        look("alias_miss_40", 32'h0000_0040, 1'b0, 1'b0, 32'h0);
        look("alias_hit_140", 32'h0000_0140, 1'b1, 1'b1, 32'h0000_0300);

        cycle("nobr_miss", 32'h0000_0140, 32'h0000_0040, 1'b0, 1'b0, 32'h0);
        look("nobr_noop", 32'h0000_0140, 1'b1, 1'b1, 32'h0000_0300);
        cycle("nobr_hit", 32'h0000_0140, 32'h0000_0140, 1'b0, 1'b0, 32'h0);
        look("nobr_cleared", 32'h0000_0140, 1'b0, 1'b0, 32'h0);

        cycle("realloc_40", 32'h0000_0040, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0200);
        drive(32'h0000_0040, 1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0400, 1'b0);
        #1;
        check_model("same_cycle");
        check_const("same_cycle", 1'b1, 1'b1, 32'h0000_0200);
        finish_cycle();
        look("same_cycle_next", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0400);

        for (int n = 0; n < 400; n++) begin
            rpc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            lpc = ($urandom_range(0, 1) == 0) ? rpc
                : ((32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2));
            drive(lpc, 1'($urandom_range(0, 3) != 0), rpc, 1'($urandom_range(0, 4) != 0),
                  1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)));
            #1;
            check_model("random");
            finish_cycle();
        end

        cycle("pre_rst_40", 32'h0000_0040, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0600);
        cycle("pre_rst_84", 32'h0000_0084, 32'h0000_0084, 1'b1, 1'b1, 32'h0000_0700);
        drive(32'h0000_0040, 1'b1, 32'h0000_0084, 1'b1, 1'b1, 32'h0000_0800, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_const("mid_reset", 1'b0, 1'b0, 32'h0);
        model_reset();
        @(posedge clk);
        #2;
        rst     = 1'b0;
        u_valid = 1'b0;
        #1;
        look("post_rst_40", 32'h0000_0040, 1'b0, 1'b0, 32'h0);
        look("post_rst_84", 32'h0000_0084, 1'b0, 1'b0, 32'h0);
`ifdef BRANCH_PREDICTOR_STATS_EN
        check("post_rst_branch_count", branch_count, 32'h0);
        check("post_rst_mispredict_count", mispredict_count, 32'h0);
`endif
        cycle("post_rst_alloc", 32'h0000_0084, 32'h0000_0084, 1'b1, 1'b0, 32'h0000_0900);
        look("post_rst_hit", 32'h0000_0084, 1'b1, 1'b0, 32'h0000_0900);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
